// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type, fault NOP word and byte-address fault decode
package imem_pkg;
  typedef enum logic {LOAD, RUN} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  function automatic logic addr_fault(input logic [31:0] a, input int unsigned dl2);
    return (a[1:0] != 2'b00) || ((a >> (dl2 + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: shares one imem between loader (ld_*) and core fetch (fetch_*); drives mem_*, holds core via core_hold, reports ld_count/ld_err
module imem_load_fetch_ctrl #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [31:0] NOP_INSTR  = imem_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_pc,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_instr,
  output logic                  fetch_err,
  output logic                  core_hold,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [DEPTH_LOG2:0]   ld_count,
  output logic                  ld_err
);
  import imem_pkg::*;
  localparam int CW = DEPTH_LOG2 + 1;
  state_e state_q, state_d;
  logic [CW-1:0] ld_count_q, ld_count_d;
  logic ld_err_q, ld_err_d, fetch_valid_q, fetch_valid_d, fetch_err_q, fetch_err_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic is_load, ld_fault, pc_fault, ld_acc, go_run, do_reload, fire;
  always_comb begin
    is_load       = state_q == LOAD;
    ld_fault      = addr_fault(ld_addr, DEPTH_LOG2);
    pc_fault      = addr_fault(fetch_pc, DEPTH_LOG2);
    ld_acc        = is_load & ld_valid;
    go_run        = ld_acc & ld_last;
    do_reload     = ~is_load & reload;
    fire          = ~is_load & fetch_req & ~reload;
    mem_we        = ld_acc & ~ld_fault;
    mem_addr      = is_load ? ld_addr[DEPTH_LOG2+1:2] : fetch_pc[DEPTH_LOG2+1:2];
    mem_wdata     = ld_data;
    state_d       = go_run ? RUN : do_reload ? LOAD : state_q;
    ld_count_d    = do_reload ? '0 : (mem_we & ~ld_count_q[DEPTH_LOG2]) ? ld_count_q + CW'(1) : ld_count_q;
    ld_err_d      = do_reload ? 1'b0 : ld_err_q | (ld_acc & ld_fault);
    fetch_valid_d = fire;
    fetch_instr_d = fire ? (pc_fault ? NOP_INSTR : mem_rdata) : fetch_instr_q;
    fetch_err_d   = fire ? pc_fault : fetch_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      ld_count_q    <= '0;
      ld_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_count_q    <= ld_count_d;
      ld_err_q      <= ld_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_err_q   <= fetch_err_d;
    end
  end
  assign ld_ready    = is_load;
  assign core_hold   = is_load;
  assign ld_count    = ld_count_q;
  assign ld_err      = ld_err_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_err   = fetch_err_q;
endmodule
